// File: rtl/cond_issue_queue.sv
// cond_issue_queue: buffers fetched instructions in a small FIFO and evaluates
// the ARM condition field of the head entry against the live NZCV flags.
// Passing instructions go to a valid/ready output register. Failing ones are
// dropped and counted.
module cond_issue_queue #(
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int NV_MODE = 0,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [3:0]               flags,
  input  logic                     flags_busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic                     drop_pulse,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          ev;
  logic [DW-1:0] head;
  logic          pass;

  // Returns 1 when condition code c holds for flags f = {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cf;
      4'h3:    r = !cf;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cf && !z;
      4'h9:    r = !cf || z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = z || (n != v);
      4'hE:    r = 1'b1;
      default: r = (NV_MODE != 0);
    endcase
    return r;
  endfunction

  // Occupancy-derived handshakes; push is refused when full even if a pop
  // happens in the same cycle, so in_ready depends on level only.
  always_comb begin
    full     = (level == LW'(DEPTH));
    empty    = (level == '0);
    in_ready = !full;
    push     = in_valid && !full;
    ev       = !empty && !flags_busy && (!out_valid || out_ready);
    head     = mem[rd_ptr];
    pass     = cond_ok(head[DW-1 -: 4], flags);
  end

  // Storage array; stale contents are harmless because pointers gate access.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointer and occupancy bookkeeping; a same-cycle push and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (ev)   rd_ptr <= rd_ptr + AW'(1);
      case ({push, ev})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Output register, drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else if (ev) begin
      if (pass) begin
        out_data   <= head;
        out_valid  <= 1'b1;
        drop_pulse <= 1'b0;
      end else begin
        out_valid  <= 1'b0;
        drop_pulse <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
    end else begin
      drop_pulse <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
